// File: rtl/lsu_bus_ctrl.sv
// Load/store unit to AHB-Lite master bridge: one outstanding transfer, no pipelining.
// Latency: accept N, NONSEQ N+1, data N+2, response pulse N+3; each wait state adds one cycle.
// Backpressure: s_ready_o low while a transfer is in flight; requests presented while not ready are ignored.
module lsu_bus_ctrl (
  input  logic        s_clk_i,
  input  logic        s_resetn_i,
  input  logic        s_req_i,
  output logic        s_ready_o,
  input  logic [31:0] s_addr_i,
  input  logic        s_write_i,
  input  logic [1:0]  s_size_i,
  input  logic [31:0] s_wdata_i,
  input  logic        s_unsigned_i,
  output logic [31:0] s_haddr_o,
  output logic        s_hwrite_o,
  output logic [2:0]  s_hsize_o,
  output logic [1:0]  s_htrans_o,
  output logic [31:0] s_hwdata_o,
  input  logic        s_hready_i,
  input  logic        s_hresp_i,
  input  logic [31:0] s_hrdata_i,
  output logic        s_resp_valid_o,
  output logic [31:0] s_rdata_o,
  output logic [1:0]  s_alignment_o,
  output logic        s_lword_o,
  output logic        s_lhalf_o,
  output logic        s_unsigned_o,
  output logic        s_berr_o,
  output logic        s_misaligned_o
);

  typedef enum logic [1:0] {ST_IDLE, ST_ADDR, ST_DATA} state_t;

  state_t      r_state;
  logic [31:0] r_haddr;
  logic        r_hwrite;
  logic [1:0]  r_size;       // normalised: 11 never stored, folded to word
  logic [31:0] r_hwdata;     // lane-replicated store data, zero for loads
  logic        r_unsigned_q; // unsigned flag of the transfer in flight
  logic        r_resp_valid;
  logic [31:0] r_rdata;
  logic [1:0]  r_alignment;
  logic        r_lword;
  logic        r_lhalf;
  logic        r_unsigned;
  logic        r_berr;
  logic        r_misaligned;

  logic        w_accept;
  logic [1:0]  w_size;
  logic        w_misaligned;
  logic [31:0] w_wdata_rep;

  // Request decode: size normalisation, alignment check and store lane replication
  always_comb begin
    w_accept     = s_req_i & s_ready_o;
    w_size       = (s_size_i == 2'b11) ? 2'b10 : s_size_i;
    w_misaligned = ((w_size == 2'b01) & s_addr_i[0]) |
                   ((w_size == 2'b10) & (s_addr_i[1:0] != 2'b00));
    case (w_size)
      2'b00:   w_wdata_rep = {4{s_wdata_i[7:0]}};
      2'b01:   w_wdata_rep = {2{s_wdata_i[15:0]}};
      default: w_wdata_rep = s_wdata_i;
    endcase
  end

  // Transfer FSM with registered bus-side and response-side outputs
  always_ff @(posedge s_clk_i or negedge s_resetn_i) begin
    if (!s_resetn_i) begin
      r_state      <= ST_IDLE;
      r_haddr      <= '0;
      r_hwrite     <= 1'b0;
      r_size       <= 2'b00;
      r_hwdata     <= '0;
      r_unsigned_q <= 1'b0;
      r_resp_valid <= 1'b0;
      r_rdata      <= '0;
      r_alignment  <= 2'b00;
      r_lword      <= 1'b0;
      r_lhalf      <= 1'b0;
      r_unsigned   <= 1'b0;
      r_berr       <= 1'b0;
      r_misaligned <= 1'b0;
    end else begin
      r_resp_valid <= 1'b0;
      r_berr       <= 1'b0;
      r_misaligned <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            if (w_misaligned) begin
              // Complete locally on the next cycle; the bus never sees it
              r_resp_valid <= 1'b1;
              r_misaligned <= 1'b1;
              r_rdata      <= '0;
              r_alignment  <= s_addr_i[1:0];
              r_lword      <= 1'b0;
              r_lhalf      <= 1'b0;
              r_unsigned   <= s_unsigned_i;
            end else begin
              r_haddr      <= s_addr_i;
              r_hwrite     <= s_write_i;
              r_size       <= w_size;
              r_hwdata     <= s_write_i ? w_wdata_rep : 32'h0;
              r_unsigned_q <= s_unsigned_i;
              r_state      <= ST_ADDR;
            end
          end
        end
        ST_ADDR: begin
          if (s_hready_i) r_state <= ST_DATA;
        end
        ST_DATA: begin
          // hresp is only meaningful on the hready=1 cycle of an error response
          if (s_hready_i) begin
            r_resp_valid <= 1'b1;
            r_berr       <= s_hresp_i;
            r_rdata      <= r_hwrite ? 32'h0 : s_hrdata_i;
            r_alignment  <= r_haddr[1:0];
            r_lword      <= ~r_hwrite & r_size[1];
            r_lhalf      <= ~r_hwrite & (r_size == 2'b01);
            r_unsigned   <= r_unsigned_q;
            r_state      <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Output mapping; htrans, ready and hwdata depend only on the current state
  always_comb begin
    s_ready_o      = (r_state == ST_IDLE);
    s_htrans_o     = (r_state == ST_ADDR) ? 2'b10 : 2'b00;
    s_haddr_o      = r_haddr;
    s_hwrite_o     = r_hwrite;
    s_hsize_o      = {1'b0, r_size};
    s_hwdata_o     = (r_state == ST_DATA) ? r_hwdata : 32'h0;
    s_resp_valid_o = r_resp_valid;
    s_rdata_o      = r_rdata;
    s_alignment_o  = r_alignment;
    s_lword_o      = r_lword;
    s_lhalf_o      = r_lhalf;
    s_unsigned_o   = r_unsigned;
    s_berr_o       = r_berr;
    s_misaligned_o = r_misaligned;
  end

endmodule

// File: tb/tb_lsu_bus_ctrl.sv
// Scoreboard bench for lsu_bus_ctrl: directed requests push expected responses,
// a negedge monitor pops and compares every response pulse, including its cycle.
// The bench plays the AHB slave, driving hready/hresp/hrdata per cycle.
module tb_lsu_bus_ctrl;

  logic        clk, rst_n;
  logic        req, ready;
  logic [31:0] addr, wdata;
  logic        write, uns;
  logic [1:0]  size;
  logic [31:0] haddr, hwdata, hrdata, rdata;
  logic        hwrite, hready, hresp;
  logic [2:0]  hsize;
  logic [1:0]  htrans, align;
  logic        resp_valid, lword, lhalf, uns_o, berr, mis;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  typedef struct {
    logic [31:0] rdata;
    logic [1:0]  align;
    logic        lword, lhalf, uns, berr, mis;
    int          cyc;
  } exp_t;
  exp_t sb[$];

  lsu_bus_ctrl dut (
    .s_clk_i(clk), .s_resetn_i(rst_n), .s_req_i(req), .s_ready_o(ready),
    .s_addr_i(addr), .s_write_i(write), .s_size_i(size), .s_wdata_i(wdata),
    .s_unsigned_i(uns), .s_haddr_o(haddr), .s_hwrite_o(hwrite), .s_hsize_o(hsize),
    .s_htrans_o(htrans), .s_hwdata_o(hwdata), .s_hready_i(hready), .s_hresp_i(hresp),
    .s_hrdata_i(hrdata), .s_resp_valid_o(resp_valid), .s_rdata_o(rdata),
    .s_alignment_o(align), .s_lword_o(lword), .s_lhalf_o(lhalf),
    .s_unsigned_o(uns_o), .s_berr_o(berr), .s_misaligned_o(mis)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // Monitor: every response pulse must match the oldest expected entry
  always @(negedge clk) begin
    if (rst_n && resp_valid) begin
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_resp: response at cycle %0d with nothing pending", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("resp_cycle", cyc, e.cyc);
        chk("resp_rdata", rdata, e.rdata);
        chk("resp_align", {30'd0, align}, {30'd0, e.align});
        chk("resp_flags", {27'd0, lword, lhalf, uns_o, berr, mis},
            {27'd0, e.lword, e.lhalf, e.uns, e.berr, e.mis});
      end
      chk("berr_and_mis_exclusive", {31'd0, berr & mis}, 32'd0);
    end
  end

  // Issue one request and play the slave; expected values are hand-computed by the caller
  task automatic do_req(input logic [31:0] a, input logic w, input logic [1:0] sz,
                        input logic [31:0] wd, input logic u, input int waits,
                        input logic err, input logic [31:0] slave_rd,
                        input logic e_mis, input logic [2:0] e_hsize,
                        input logic [31:0] e_hwdata, input logic [31:0] e_rdata,
                        input logic e_lword, input logic e_lhalf);
    exp_t e;
    int acc;
    @(negedge clk);
    chk("ready_idle", {31'd0, ready}, 32'd1);
    req = 1'b1; addr = a; write = w; size = sz; wdata = wd; uns = u;
    hready = 1'b1; hresp = 1'b0; hrdata = slave_rd;
    acc = cyc;
    e.rdata = e_rdata; e.align = a[1:0]; e.lword = e_lword; e.lhalf = e_lhalf;
    e.uns = u; e.berr = err & ~e_mis; e.mis = e_mis;
    e.cyc = e_mis ? acc + 1 : acc + 3 + waits;
    sb.push_back(e);
    @(negedge clk);
    req = 1'b0;
    if (e_mis) begin
      chk("mis_no_htrans", {30'd0, htrans}, 32'd0);
      @(negedge clk);
      chk("mis_no_htrans2", {30'd0, htrans}, 32'd0);
    end else begin
      chk("addr_htrans", {30'd0, htrans}, 32'h2);
      chk("addr_haddr", haddr, a);
      chk("addr_hsize", {29'd0, hsize}, {29'd0, e_hsize});
      chk("addr_hwrite", {31'd0, hwrite}, {31'd0, w});
      chk("addr_ready", {31'd0, ready}, 32'd0);
      @(negedge clk);
      // Wait states: a competing request must be ignored while busy
      for (int i = 0; i < waits; i++) begin
        hready = 1'b0;
        hresp  = err && (i == waits - 1);
        req = 1'b1; addr = 32'h500; write = 1'b1; size = 2'b10;
        chk("wait_ready", {31'd0, ready}, 32'd0);
        chk("wait_htrans", {30'd0, htrans}, 32'd0);
        chk("wait_hwdata", hwdata, e_hwdata);
        @(negedge clk);
      end
      req = 1'b0;
      hready = 1'b1; hresp = err;
      chk("data_hwdata", hwdata, e_hwdata);
      chk("data_ready", {31'd0, ready}, 32'd0);
      @(negedge clk);
      hresp = 1'b0;
    end
  endtask

  initial begin
    rst_n = 1'b0; req = 1'b0; addr = '0; write = 1'b0; size = 2'b00; wdata = '0;
    uns = 1'b0; hready = 1'b1; hresp = 1'b0; hrdata = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_htrans", {30'd0, htrans}, 32'd0);
    chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst_haddr", haddr, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_ready", {31'd0, ready}, 32'd1);
    @(posedge clk); #1 rst_n = 1'b1;

    // Load word, zero wait
    do_req(32'h100, 0, 2'b10, 32'h0, 0, 0, 0, 32'hDEADBEEF, 0, 3'b010, 32'h0, 32'hDEADBEEF, 1, 0);
    @(negedge clk);
    chk("hold_rdata", rdata, 32'hDEADBEEF);
    chk("hold_valid_low", {31'd0, resp_valid}, 32'd0);
    // Store byte
    do_req(32'h203, 1, 2'b00, 32'h000000A5, 0, 0, 0, 32'h77777777, 0, 3'b000, 32'hA5A5A5A5, 32'h0, 0, 0);
    // Load half, three wait states, unsigned
    do_req(32'h102, 0, 2'b01, 32'h0, 1, 3, 0, 32'h12345678, 0, 3'b001, 32'h0, 32'h12345678, 0, 1);
    // Misaligned load word
    do_req(32'h101, 0, 2'b10, 32'h0, 0, 0, 0, 32'h0, 1, 3'b010, 32'h0, 32'h0, 0, 0);
    // Two-cycle error response
    do_req(32'h104, 0, 2'b10, 32'h0, 0, 1, 1, 32'h0BAD0BAD, 0, 3'b010, 32'h0, 32'h0BAD0BAD, 1, 0);
    // Store half, store with size 11 (word)
    do_req(32'h206, 1, 2'b01, 32'hFFFF1234, 0, 0, 0, 32'h0, 0, 3'b001, 32'h12341234, 32'h0, 0, 0);
    do_req(32'h208, 1, 2'b11, 32'hCAFEF00D, 0, 1, 0, 32'h0, 0, 3'b010, 32'hCAFEF00D, 32'h0, 0, 0);
    // Misaligned half store, then load byte unsigned
    do_req(32'h301, 1, 2'b01, 32'h1234, 0, 0, 0, 32'h0, 1, 3'b001, 32'h0, 32'h0, 0, 0);
    do_req(32'h003, 0, 2'b00, 32'h0, 1, 0, 0, 32'h11223344, 0, 3'b000, 32'h0, 32'h11223344, 0, 0);

    // Reset while stalled in the data phase: no response may follow
    @(negedge clk);
    req = 1'b1; addr = 32'h300; write = 1'b0; size = 2'b10; hready = 1'b1;
    @(negedge clk);
    req = 1'b0;
    @(negedge clk);
    hready = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_htrans", {30'd0, htrans}, 32'd0);
    chk("midrst_valid", {31'd0, resp_valid}, 32'd0);
    chk("midrst_ready", {31'd0, ready}, 32'd1);
    hready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    // Fresh request in the first clock after release
    do_req(32'h400, 0, 2'b10, 32'h0, 0, 0, 0, 32'h600DF00D, 0, 3'b010, 32'h0, 32'h600DF00D, 1, 0);

    repeat (3) @(negedge clk);
    chk("sb_drained", sb.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/lsu_bus_ctrl.md
LSU_BUS_CTRL -- requirements
Module: lsu_bus_ctrl

Interface
REQ-001 s_clk_i  in  1  clock; all state updates on rising edge.
REQ-002 s_resetn_i  in  1  asynchronous active-low reset.
REQ-003 s_req_i  in  1  load/store request valid.
REQ-004 s_ready_o  out  1  request accepted when s_req_i & s_ready_o.
REQ-005 s_addr_i  in  32  byte address.
REQ-006 s_write_i  in  1  1=store, 0=load.
REQ-007 s_size_i  in  2  00 byte, 01 half, 10 word; 11 treated as word.
REQ-008 s_wdata_i  in  32  store data, right-aligned.
REQ-009 s_unsigned_i  in  1  load zero-extends; carried to response.
REQ-010 AHB-Lite master: s_haddr_o out 32, s_hwrite_o out 1, s_hsize_o out 3, s_htrans_o out 2, s_hwdata_o out 32, s_hready_i in 1, s_hresp_i in 1, s_hrdata_i in 32.
REQ-011 s_resp_valid_o  out  1  one-cycle completion pulse.
REQ-012 s_rdata_o  out  32  raw captured s_hrdata_i (unshifted).
REQ-013 s_alignment_o  out  2  s_addr_i[1:0] of completed request.
REQ-014 s_lword_o / s_lhalf_o / s_unsigned_o  out  1 each  load-format flags of completed request, feed the load data decoder.
REQ-015 s_berr_o  out  1  bus error; s_misaligned_o  out  1  misaligned request, no bus transfer.

Function
REQ-016 FSM states: IDLE, ADDR, DATA; one outstanding transfer, no pipelining.
REQ-017 s_ready_o SHALL be 1 only in IDLE and when s_resp_valid_o is 0 or being cleared this cycle (combinational from state).
REQ-018 Misaligned: half with addr[0]=1, or word with addr[1:0]!=00; on acceptance stay IDLE, no htrans, next cycle s_resp_valid_o=1, s_misaligned_o=1.
REQ-019 Aligned acceptance in IDLE: register addr/write/size/wdata/unsigned; next state ADDR.
REQ-020 ADDR: s_htrans_o=2'b10 (NONSEQ), s_haddr_o=registered addr, s_hsize_o={1'b0,size}, s_hwrite_o=registered write; held stable until s_hready_i=1, then DATA.
REQ-021 Outside ADDR s_htrans_o=2'b00 (IDLE); s_haddr_o, s_hsize_o, s_hwrite_o hold last values.
REQ-022 DATA: s_hwdata_o = byte {4{wdata[7:0]}}, half {2{wdata[15:0]}}, word wdata; driven for stores, 0 for loads.
REQ-023 DATA with s_hready_i=1: capture s_hrdata_i (loads; 0 for stores), s_berr_o<=s_hresp_i, go IDLE; s_resp_valid_o=1 on following cycle.
REQ-024 DATA with s_hready_i=0: remain, outputs stable, s_hresp_i ignored (AHB two-cycle error completes on the hready=1 cycle).
REQ-025 Latency, zero wait states: accept cycle N, NONSEQ N+1, data phase N+2, s_resp_valid_o N+3; each wait state adds one cycle.
REQ-026 s_lword_o = ~write & size>=10; s_lhalf_o = ~write & size==01; both 0 for stores and misaligned.
REQ-027 s_resp_valid_o, s_berr_o, s_misaligned_o are single-cycle pulses; s_rdata_o, s_alignment_o and flags hold until next completion.
REQ-028 s_berr_o and s_misaligned_o never both 1.
REQ-029 s_req_i while not ready: ignored, no state captured.

Reset
REQ-030 Async assertion forces IDLE, s_htrans_o=00, s_resp_valid_o=0, all other registered outputs 0, regardless of bus phase.
REQ-031 After deassertion first request acceptable in the first clock; an in-flight transfer interrupted by reset produces no response.

Verification
REQ-032 Load word addr 0x100, hready=1 always, hrdata=0xDEADBEEF -> NONSEQ cycle 1, resp cycle 3, rdata=0xDEADBEEF, alignment=00, lword=1, berr=0.
REQ-033 Store byte addr 0x203 wdata=0x000000A5 -> hsize=000, haddr=0x203, hwrite=1, hwdata=0xA5A5A5A5, resp with lword=lhalf=0.
REQ-034 Load half addr 0x102, hready low 3 cycles in data phase -> resp 3 cycles later than zero-wait, alignment=10, lhalf=1, ready=0 throughout.
REQ-035 Load word addr 0x101 -> htrans stays 00, resp next cycle, misaligned=1, berr=0.
REQ-036 Load word with two-cycle error (hready=0/hresp=1, then hready=1/hresp=1) -> resp valid, berr=1, one pulse.
REQ-037 Reset asserted while in DATA with hready=0 -> htrans=00, no resp pulse; fresh request after release completes normally.
